// File: rtl/pc_jump_sequencer.sv
// Program-counter sequencer: steps the PC on fetch-advance and resolves
// conditional relative jumps. Optional taken-jump counter via PC_JUMP_COUNT_EN.
module pc_jump_sequencer #(
    parameter int              WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             halt,
    input  logic             jmp_valid,
    output logic             jmp_ready,
    input  logic [1:0]       jmp_cond,
    input  logic [WIDTH-1:0] cmp_a,
    input  logic [WIDTH-1:0] cmp_b,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             flush,
    output logic             taken,
    output logic [15:0]      taken_count
);

    typedef enum logic [1:0] {
        S_RUN,
        S_RESOLVE,
        S_FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [1:0]       cond_q, cond_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] off_q, off_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic             cond_true;

    // Operands are compared as signed two's complement.
    always_comb begin
        cond_true = 1'b0;
        case (cond_q)
            2'b00:   cond_true = 1'b1;
            2'b01:   cond_true = $signed(a_q) < $signed(b_q);
            2'b10:   cond_true = $signed(a_q) > $signed(b_q);
            default: cond_true = (a_q == b_q);
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cond_d  = cond_q;
        a_d     = a_q;
        b_d     = b_q;
        off_d   = off_q;
        base_d  = base_q;
        case (state_q)
            S_RUN: begin
                if (!halt) begin
                    if (jmp_valid) begin
                        cond_d  = jmp_cond;
                        a_d     = cmp_a;
                        b_d     = cmp_b;
                        off_d   = offset;
                        base_d  = pc_q;
                        state_d = S_RESOLVE;
                    end else if (advance) begin
                        pc_d = pc_q + WIDTH'(1);
                    end
                end
            end
            S_RESOLVE: begin
                if (cond_true) begin
                    pc_d    = base_q + off_q;
                    state_d = S_FLUSH;
                end else begin
                    pc_d    = base_q + WIDTH'(1);
                    state_d = S_RUN;
                end
            end
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            cond_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            off_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cond_q  <= cond_d;
            a_q     <= a_d;
            b_q     <= b_d;
            off_q   <= off_d;
            base_q  <= base_d;
        end
    end

    assign jmp_ready = (state_q == S_RUN) && !halt;
    assign pc_valid  = (state_q == S_RUN) && !halt;
    assign flush     = (state_q == S_FLUSH);
    assign taken     = (state_q == S_FLUSH);
    assign pc        = pc_q;

`ifdef PC_JUMP_COUNT_EN
    logic [15:0] count_q, count_d;

    // Saturating count of FLUSH cycles, i.e. taken jumps.
    always_comb begin
        count_d = count_q;
        if ((state_q == S_FLUSH) && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign taken_count = count_q;
`else
    assign taken_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_jump_sequencer.sv
// Self-checking bench for pc_jump_sequencer: directed vector table, corner
// sequences and randomized operations against a transaction-level model.
module tb_pc_jump_sequencer;

   localparam logic [15:0] RST_PC = 16'h0000;
`ifdef PC_JUMP_COUNT_EN
   localparam bit COUNT_EN = 1'b1;
`else
   localparam bit COUNT_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        advance;
   logic        halt;
   logic        jmp_valid;
   logic        jmp_ready;
   logic [1:0]  jmp_cond;
   logic [15:0] cmp_a;
   logic [15:0] cmp_b;
   logic [15:0] offset;
   logic [15:0] pc;
   logic        pc_valid;
   logic        flush;
   logic        taken;
   logic [15:0] taken_count;

   int checks = 0;
   int errors = 0;
   logic [15:0] model_pc;
   int          model_count;

   pc_jump_sequencer #(.WIDTH(16), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .advance(advance), .halt(halt),
      .jmp_valid(jmp_valid), .jmp_ready(jmp_ready), .jmp_cond(jmp_cond),
      .cmp_a(cmp_a), .cmp_b(cmp_b), .offset(offset), .pc(pc),
      .pc_valid(pc_valid), .flush(flush), .taken(taken),
      .taken_count(taken_count)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guarantees termination even if the bench itself gets stuck.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [15:0] start_pc;
      logic [1:0]  cond;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] off;
      logic [15:0] exp_pc;
      logic        exp_taken;
   } vec_t;

   vec_t vecs[10];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic adv, input logic hlt, input logic v,
                                input logic [1:0] c, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] o);
      advance   = adv;
      halt      = hlt;
      jmp_valid = v;
      jmp_cond  = c;
      cmp_a     = a;
      cmp_b     = b;
      offset    = o;
   endtask

   // Reference rules, expressed on plain signed integers.
   function automatic int sval(input logic [15:0] v);
      return (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
   endfunction

   function automatic logic refTaken(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b);
      case (c)
         2'd0:    return 1'b1;
         2'd1:    return sval(a) < sval(b);
         2'd2:    return sval(a) > sval(b);
         default: return a == b;
      endcase
   endfunction

   function automatic logic [15:0] refTarget(input logic [15:0] base, input logic [15:0] o, input logic tk);
      int sum;
      sum = tk ? (int'(base) + int'(o)) % 65536 : (int'(base) + 1) % 65536;
      return 16'(sum);
   endfunction

   task automatic checkCount(input string name);
      checkOutput(name, 32'(taken_count), 32'(COUNT_EN ? model_count : 0));
   endtask

   // One cycle in RUN that must not accept a request (halted or no valid).
   task automatic runCycle(input logic adv, input logic hlt, input logic v);
      applyStimulus(adv, hlt, v, 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      #1;
      checkOutput("run_pc", 32'(pc), 32'(model_pc));
      checkOutput("run_ready", 32'(jmp_ready), 32'(!hlt));
      checkOutput("run_pc_valid", 32'(pc_valid), 32'(!hlt));
      checkOutput("run_flush", 32'(flush), 32'(0));
      checkOutput("run_taken", 32'(taken), 32'(0));
      checkCount("run_count");
      @(posedge clk); #1;
      if (!hlt && adv) model_pc = 16'((int'(model_pc) + 1) % 65536);
   endtask

   // Full jump transaction: accept, resolve, optional flush, back in RUN.
   task automatic doJump(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] o, input logic [15:0] exp_pc, input logic exp_tk);
      logic [15:0] base;
      base = model_pc;
      applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b1, c, a, b, o);
      #1;
      checkOutput("acc_ready", 32'(jmp_ready), 32'(1));
      checkOutput("acc_pc", 32'(pc), 32'(base));
      checkOutput("acc_pc_valid", 32'(pc_valid), 32'(1));
      checkOutput("acc_flush", 32'(flush), 32'(0));
      checkCount("acc_count");
      @(posedge clk); #1;
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom));
      #1;
      checkOutput("res_ready", 32'(jmp_ready), 32'(0));
      checkOutput("res_pc_valid", 32'(pc_valid), 32'(0));
      checkOutput("res_pc", 32'(pc), 32'(base));
      checkOutput("res_flush", 32'(flush), 32'(0));
      @(posedge clk); #1;
      if (exp_tk) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         #1;
         checkOutput("fl_flush", 32'(flush), 32'(1));
         checkOutput("fl_taken", 32'(taken), 32'(1));
         checkOutput("fl_pc", 32'(pc), 32'(exp_pc));
         checkOutput("fl_pc_valid", 32'(pc_valid), 32'(0));
         checkOutput("fl_ready", 32'(jmp_ready), 32'(0));
         checkCount("fl_count");
         @(posedge clk); #1;
         if (model_count < 65535) model_count++;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
      #1;
      checkOutput("back_pc", 32'(pc), 32'(exp_pc));
      checkOutput("back_pc_valid", 32'(pc_valid), 32'(1));
      checkOutput("back_flush", 32'(flush), 32'(0));
      checkOutput("back_taken", 32'(taken), 32'(0));
      model_pc = exp_pc;
   endtask

   task automatic gotoPc(input logic [15:0] t);
      doJump(2'd0, 16'd0, 16'd0, 16'((int'(t) - int'(model_pc)) & 16'hFFFF), t, 1'b1);
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom));
      @(posedge clk); #1;
      rst = 1'b0;
      model_pc    = RST_PC;
      model_count = 0;
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
      #1;
      checkOutput("rst_pc", 32'(pc), 32'(RST_PC));
      checkOutput("rst_pc_valid", 32'(pc_valid), 32'(1));
      checkOutput("rst_flush", 32'(flush), 32'(0));
      checkOutput("rst_taken", 32'(taken), 32'(0));
      checkOutput("rst_count", 32'(taken_count), 32'(0));
   endtask

   initial begin
      logic [1:0]  rc;
      logic [15:0] ra, rb, ro, tgt;
      logic        tk;

      vecs[0] = '{16'h0010, 2'd0, 16'h0000, 16'h0000, 16'h0005, 16'h0015, 1'b1};
      vecs[1] = '{16'h0020, 2'd1, 16'hFFFF, 16'h0001, 16'hFFF0, 16'h0010, 1'b1};
      vecs[2] = '{16'h0020, 2'd2, 16'hFFFF, 16'h0001, 16'hFFF0, 16'h0021, 1'b0};
      vecs[3] = '{16'hFFFE, 2'd3, 16'h0007, 16'h0007, 16'h0004, 16'h0002, 1'b1};
      vecs[4] = '{16'h0100, 2'd0, 16'h1111, 16'h2222, 16'h0000, 16'h0100, 1'b1};
      vecs[5] = '{16'h0100, 2'd1, 16'h0001, 16'hFFFF, 16'h0050, 16'h0101, 1'b0};
      vecs[6] = '{16'h0200, 2'd2, 16'h7FFF, 16'h8000, 16'h0010, 16'h0210, 1'b1};
      vecs[7] = '{16'h0300, 2'd3, 16'h1234, 16'h1235, 16'h0008, 16'h0301, 1'b0};
      vecs[8] = '{16'hFFFF, 2'd1, 16'h8000, 16'h7FFF, 16'h0003, 16'h0002, 1'b1};
      vecs[9] = '{16'hFFFF, 2'd2, 16'h0005, 16'h0005, 16'h0003, 16'h0000, 1'b0};

      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
      repeat (2) @(posedge clk);
      #1;
      doReset();

      $display("[TB] sequential advance");
      for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b0, 1'b0);
      runCycle(1'b0, 1'b0, 1'b0);
      checkOutput("adv_pc3", 32'(model_pc), 32'(16'h0003));

      $display("[TB] directed jump table");
      for (int i = 0; i < 10; i++) begin
         gotoPc(vecs[i].start_pc);
         doJump(vecs[i].cond, vecs[i].a, vecs[i].b, vecs[i].off, vecs[i].exp_pc, vecs[i].exp_taken);
      end

      $display("[TB] advance wrap");
      gotoPc(16'hFFFF);
      runCycle(1'b1, 1'b0, 1'b0);
      runCycle(1'b0, 1'b0, 1'b0);
      checkOutput("wrap_pc", 32'(model_pc), 32'(16'h0000));

      $display("[TB] halt blocks requests and advance");
      gotoPc(16'h0040);
      runCycle(1'b1, 1'b1, 1'b1);
      runCycle(1'b1, 1'b1, 1'b1);
      doJump(2'd0, 16'd0, 16'd0, 16'h0010, 16'h0050, 1'b1);

      $display("[TB] taken counter");
      doReset();
      for (int i = 0; i < 3; i++) doJump(2'd0, 16'd0, 16'd0, 16'h0002, 16'(2 * (i + 1)), 1'b1);
      checkOutput("count3", 32'(taken_count), COUNT_EN ? 32'(3) : 32'(0));

      $display("[TB] reset during resolve");
      applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 16'd0, 16'd0, 16'h0100);
      #1;
      checkOutput("rr_ready", 32'(jmp_ready), 32'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_pc    = RST_PC;
      model_count = 0;
      #1;
      checkOutput("rr_pc", 32'(pc), 32'(RST_PC));
      checkOutput("rr_flush", 32'(flush), 32'(0));
      checkOutput("rr_pc_valid", 32'(pc_valid), 32'(1));
      checkOutput("rr_count", 32'(taken_count), 32'(0));
      runCycle(1'b0, 1'b0, 1'b0);

      $display("[TB] randomized operations");
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 19))
            0, 1, 2, 3, 4, 5, 6, 7: begin
               rc = 2'($urandom);
               ra = 16'($urandom);
               rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
               ro = 16'($urandom);
               tk  = refTaken(rc, ra, rb);
               tgt = refTarget(model_pc, ro, tk);
               doJump(rc, ra, rb, ro, tgt, tk);
            end
            8, 9, 10, 11, 12, 13: runCycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            14, 15: runCycle(1'($urandom), 1'b1, 1'b1);
            16, 17, 18: runCycle(1'b0, 1'b0, 1'b0);
            default: doReset();
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
